// File: rtl/nios2_oci_dct_capture.sv
// Debug-capture-trace packer: packs narrow trace entries LSB-first into words,
// queues them in a show-ahead FIFO and sequences the end-of-test flush.
module nios2_oci_dct_capture #(
  parameter int ENTRY_W = 10,
  parameter int ENTRIES = 3,
  parameter int CNT_W   = 4,
  parameter int DEPTH   = 8,
  parameter int DROP_W  = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         entry_valid,
  input  logic [ENTRY_W-1:0]           entry_data,
  input  logic                         test_ending,
  input  logic                         rd_ready,
  output logic                         rd_valid,
  output logic [ENTRY_W*ENTRIES-1:0]   rd_data,
  output logic [CNT_W-1:0]             rd_count,
  output logic [ENTRY_W*ENTRIES-1:0]   dct_buffer,
  output logic [CNT_W-1:0]             dct_count,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic                         overflow,
  output logic [DROP_W-1:0]            dropped_words,
  output logic                         test_has_ended
);

  localparam int WORD_W = ENTRY_W * ENTRIES;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LVL_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(ENTRIES - 1);
  localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_FLUSH = 2'd1,
    S_DRAIN = 2'd2,
    S_ENDED = 2'd3
  } state_t;

  state_t              r_state;
  logic [WORD_W-1:0]   r_mem_data [DEPTH];
  logic [CNT_W-1:0]    r_mem_cnt  [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [LVL_W-1:0]    r_level;
  logic [WORD_W-1:0]   r_buffer;
  logic [CNT_W-1:0]    r_count;
  logic                r_overflow;
  logic [DROP_W-1:0]   r_dropped;
  logic                r_ended;

  logic                w_pop;
  logic                w_space;
  logic                w_accept;
  logic                w_complete;
  logic                w_flush_push;
  logic                w_push;
  logic                w_drop;
  logic [WORD_W-1:0]   w_packed;
  logic [WORD_W-1:0]   w_push_data;
  logic [CNT_W-1:0]    w_push_cnt;

  // A full FIFO still has room when the head leaves on the same edge.
  assign w_pop        = (r_level != LVL_W'(0)) & rd_ready;
  assign w_space      = (r_level < FULL_LVL) | w_pop;
  assign w_accept     = (r_state == S_RUN) & entry_valid;
  assign w_complete   = w_accept & (r_count == LAST_SLOT);
  assign w_flush_push = (r_state == S_FLUSH) & (r_count != CNT_W'(0)) & w_space;
  assign w_push       = (w_complete & w_space) | w_flush_push;
  assign w_drop       = w_complete & ~w_space;

  // Insert the incoming entry into its slot of the packing register.
  always_comb begin
    w_packed = r_buffer;
    for (int i = 0; i < ENTRIES; i++) begin
      if (r_count == CNT_W'(i)) begin
        w_packed[i*ENTRY_W +: ENTRY_W] = entry_data;
      end else begin
        w_packed[i*ENTRY_W +: ENTRY_W] = r_buffer[i*ENTRY_W +: ENTRY_W];
      end
    end
  end

  // Select the word written into the FIFO: a completed word or the flushed partial.
  always_comb begin
    w_push_data = r_buffer;
    w_push_cnt  = r_count;
    if (w_complete) begin
      w_push_data = w_packed;
      w_push_cnt  = CNT_W'(ENTRIES);
    end else begin
      w_push_data = r_buffer;
      w_push_cnt  = r_count;
    end
  end

  // FIFO storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_push_data;
      r_mem_cnt[r_wr_ptr]  <= w_push_cnt;
    end
  end

  // Pointers, packing register, overflow accounting and end-of-test sequencing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_RUN;
      r_wr_ptr   <= PTR_W'(0);
      r_rd_ptr   <= PTR_W'(0);
      r_level    <= LVL_W'(0);
      r_buffer   <= WORD_W'(0);
      r_count    <= CNT_W'(0);
      r_overflow <= 1'b0;
      r_dropped  <= DROP_W'(0);
      r_ended    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase

      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropped != {DROP_W{1'b1}}) begin
          r_dropped <= r_dropped + DROP_W'(1);
        end
      end

      // The packing register clears even when a completed word is dropped.
      if (w_complete || w_flush_push) begin
        r_buffer <= WORD_W'(0);
        r_count  <= CNT_W'(0);
      end else if (w_accept) begin
        r_buffer <= w_packed;
        r_count  <= r_count + CNT_W'(1);
      end

      case (r_state)
        S_RUN: begin
          if (test_ending) begin
            r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if ((r_count == CNT_W'(0)) || w_flush_push) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (r_level == LVL_W'(0)) begin
            r_state <= S_ENDED;
            r_ended <= 1'b1;
          end
        end
        S_ENDED: begin
          r_ended <= 1'b1;
        end
        default: begin
          r_state <= S_RUN;
        end
      endcase
    end
  end

  assign rd_valid       = (r_level != LVL_W'(0));
  assign rd_data        = r_mem_data[r_rd_ptr];
  assign rd_count       = r_mem_cnt[r_rd_ptr];
  assign dct_buffer     = r_buffer;
  assign dct_count      = r_count;
  assign fifo_level     = r_level;
  assign overflow       = r_overflow;
  assign dropped_words  = r_dropped;
  assign test_has_ended = r_ended;

endmodule

// File: tb/tb_nios2_oci_dct_capture.sv
// Self-checking bench for nios2_oci_dct_capture: table-driven packing vectors,
// a queue scoreboard of expected FIFO words, and hand-written corner sequences.
module tb_nios2_oci_dct_capture;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        entry_valid;
  logic [9:0]  entry_data;
  logic        test_ending;
  logic        rd_ready;
  logic        rd_valid;
  logic [29:0] rd_data;
  logic [3:0]  rd_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic [3:0]  fifo_level;
  logic        overflow;
  logic [7:0]  dropped_words;
  logic        test_has_ended;

  nios2_oci_dct_capture #(
    .ENTRY_W(10), .ENTRIES(3), .CNT_W(4), .DEPTH(8), .DROP_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .entry_valid(entry_valid), .entry_data(entry_data),
    .test_ending(test_ending), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_data(rd_data), .rd_count(rd_count), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .fifo_level(fifo_level), .overflow(overflow),
    .dropped_words(dropped_words), .test_has_ended(test_has_ended)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] data;
    logic [3:0]  cnt;
  } exp_t;

  typedef struct packed {
    logic [9:0]  e0;
    logic [9:0]  e1;
    logic [9:0]  e2;
    logic [29:0] word;
  } vec_t;

  exp_t q[$];
  vec_t vecs[5];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare the head word against the scoreboard when it is popped, then advance a cycle.
  task automatic step();
    exp_t e;
    #1;
    if (rd_valid && rd_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pop: got 0x%0h expected no word", rd_data);
      end else begin
        e = q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(e.data));
        chk("rd_count", 32'(rd_count), 32'(e.cnt));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic [9:0] d);
    entry_valid = 1'b1;
    entry_data  = d;
    step();
    entry_valid = 1'b0;
  endtask

  function automatic logic [9:0] ent(input int k, input int j);
    return 10'((k * 3 + j + 1) & 32'h3FF);
  endfunction

  task automatic send_word(input int k, input bit expect_kept);
    exp_t e;
    e.data = {ent(k, 2), ent(k, 1), ent(k, 0)};
    e.cnt  = 4'd3;
    if (expect_kept) q.push_back(e);
    push_entry(ent(k, 0));
    push_entry(ent(k, 1));
    push_entry(ent(k, 2));
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    entry_valid = 1'b0;
    entry_data  = 10'd0;
    test_ending = 1'b0;
    rd_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    q.delete();
  endtask

  task automatic drain(input int max_cycles);
    rd_ready = 1'b1;
    for (int i = 0; i < max_cycles && q.size() > 0; i++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    vecs[0] = '{e0: 10'h001, e1: 10'h002, e2: 10'h003, word: 30'h00300801};
    vecs[1] = '{e0: 10'h3FF, e1: 10'h000, e2: 10'h3FF, word: 30'h3FF003FF};
    vecs[2] = '{e0: 10'h155, e1: 10'h2AA, e2: 10'h155, word: 30'h155AA955};
    vecs[3] = '{e0: 10'h000, e1: 10'h3FF, e2: 10'h000, word: 30'h000FFC00};
    vecs[4] = '{e0: 10'h123, e1: 10'h045, e2: 10'h3C0, word: 30'h3C011523};

    do_reset();
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_fifo_level", 32'(fifo_level), 32'd0);
    chk("rst_dct_count", 32'(dct_count), 32'd0);
    chk("rst_dct_buffer", 32'(dct_buffer), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_dropped", 32'(dropped_words), 32'd0);
    chk("rst_ended", 32'(test_has_ended), 32'd0);

    // Pack and read with the consumer always ready.
    rd_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      push_entry(vecs[v].e0);
      chk("pack1_count", 32'(dct_count), 32'd1);
      chk("pack1_buffer", 32'(dct_buffer), {22'd0, vecs[v].e0});
      push_entry(vecs[v].e1);
      chk("pack2_buffer", 32'(dct_buffer), {12'd0, vecs[v].e1, vecs[v].e0});
      e.data = vecs[v].word;
      e.cnt  = 4'd3;
      q.push_back(e);
      push_entry(vecs[v].e2);
      chk("word_level", 32'(fifo_level), 32'd1);
      chk("word_count_clr", 32'(dct_count), 32'd0);
      chk("word_buffer_clr", 32'(dct_buffer), 32'd0);
      step();
      chk("after_pop_level", 32'(fifo_level), 32'd0);
    end
    chk("table_sb_empty", 32'(q.size()), 32'd0);

    // Overflow: nine words into an eight-deep FIFO.
    do_reset();
    for (int k = 1; k <= 9; k++) send_word(k, k <= 8);
    chk("ovf_level", 32'(fifo_level), 32'd8);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_dropped", 32'(dropped_words), 32'd1);
    drain(20);
    chk("ovf_drained_level", 32'(fifo_level), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a pop on the same edge as the completing entry.
    do_reset();
    for (int k = 1; k <= 8; k++) send_word(k, 1'b1);
    push_entry(ent(9, 0));
    push_entry(ent(9, 1));
    rd_ready = 1'b1;
    e.data = {ent(9, 2), ent(9, 1), ent(9, 0)};
    e.cnt  = 4'd3;
    q.push_back(e);
    push_entry(ent(9, 2));
    rd_ready = 1'b0;
    chk("fullpop_level", 32'(fifo_level), 32'd8);
    chk("fullpop_overflow", 32'(overflow), 32'd0);
    chk("fullpop_dropped", 32'(dropped_words), 32'd0);
    drain(20);

    // Partial flush of two entries.
    do_reset();
    push_entry(10'h3FF);
    push_entry(10'h155);
    test_ending = 1'b1;
    e.data = 30'h000557FF;
    e.cnt  = 4'd2;
    q.push_back(e);
    step();
    step();
    chk("flush_level", 32'(fifo_level), 32'd1);
    chk("flush_count_clr", 32'(dct_count), 32'd0);
    rd_ready = 1'b1;
    step();
    chk("flush_popped", 32'(q.size()), 32'd0);
    step();
    chk("flush_ended", 32'(test_has_ended), 32'd1);
    chk("flush_ended_level", 32'(fifo_level), 32'd0);

    // Flush stalled behind a full FIFO.
    do_reset();
    for (int k = 1; k <= 8; k++) send_word(k, 1'b1);
    push_entry(10'h2A5);
    test_ending = 1'b1;
    repeat (5) step();
    chk("stall_level", 32'(fifo_level), 32'd8);
    chk("stall_count", 32'(dct_count), 32'd1);
    chk("stall_buffer", 32'(dct_buffer), 32'h2A5);
    chk("stall_overflow", 32'(overflow), 32'd0);
    chk("stall_dropped", 32'(dropped_words), 32'd0);
    chk("stall_not_ended", 32'(test_has_ended), 32'd0);
    e.data = 30'h2A5;
    e.cnt  = 4'd1;
    q.push_back(e);
    rd_ready = 1'b1;
    for (int i = 0; i < 40 && !test_has_ended; i++) step();
    chk("stall_sb_empty", 32'(q.size()), 32'd0);
    chk("stall_ended", 32'(test_has_ended), 32'd1);
    chk("stall_overflow_end", 32'(overflow), 32'd0);

    // Asynchronous reset mid-drain.
    do_reset();
    for (int k = 1; k <= 4; k++) send_word(k, 1'b0);
    chk("mid_level", 32'(fifo_level), 32'd4);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rd_valid", 32'(rd_valid), 32'd0);
    chk("mid_level_rst", 32'(fifo_level), 32'd0);
    chk("mid_overflow", 32'(overflow), 32'd0);
    chk("mid_ended", 32'(test_has_ended), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    q.delete();
    push_entry(10'h0AB);
    chk("restart_count", 32'(dct_count), 32'd1);
    chk("restart_buffer", 32'(dct_buffer), 32'h0AB);
    chk("restart_level", 32'(fifo_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
